// File: rtl/shift_reg_seq_if.sv
// Command/status bundle for shift_reg_seq: the master drives commands and
// serial fill, the slave returns register contents and handshake flags.
interface shift_reg_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
);
    logic             enable;
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output enable, start, mode, amt, d, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  enable, start, mode, amt, d, sin,
        output q, sout, busy, done
    );
endinterface

// File: rtl/shift_reg_seq.sv
// Loadable WIDTH-bit holding register with command-driven shift/rotate modes,
// one bit per enabled cycle, and busy/done handshaking.
module shift_reg_seq #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     AMT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic            clk,
    input logic            rst,
    shift_reg_seq_if.slave bus
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_SAR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ROR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;

    // One shift step; returns {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] shift_one(input logic [2:0]       m,
                                                 input logic [WIDTH-1:0] v,
                                                 input logic             s);
        logic [WIDTH:0] r;
        case (m)
            MODE_SHL: r = {v[WIDTH-1], v[WIDTH-2:0], s};
            MODE_SHR: r = {v[0], s, v[WIDTH-1:1]};
            MODE_SAR: r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            MODE_ROL: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            MODE_ROR: r = {v[0], v[0], v[WIDTH-1:1]};
            default:  r = {1'b0, v};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // done self-clears every edge, so it defaults low even when stalled.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        if (bus.enable) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.mode)
                            MODE_HOLD: done_d = 1'b1;
                            MODE_LOAD: begin
                                q_d    = bus.d;
                                done_d = 1'b1;
                            end
                            MODE_CLEAR: begin
                                q_d    = '0;
                                done_d = 1'b1;
                            end
                            default: begin
                                if (bus.amt == '0) begin
                                    done_d = 1'b1;
                                end else begin
                                    {sout_d, q_d} = shift_one(bus.mode, q_q, bus.sin);
                                    if (bus.amt == AMT_W'(1)) begin
                                        done_d = 1'b1;
                                    end else begin
                                        mode_d  = bus.mode;
                                        cnt_d   = bus.amt - AMT_W'(1);
                                        state_d = SHIFT;
                                    end
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    {sout_d, q_d} = shift_one(mode_q, q_q, bus.sin);
                    cnt_d = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: a per-cycle vector table plus hand-written
// multi-cycle sequences, checked through an expected-result queue.
module tb_shift_reg_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 4;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_SAR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_ROR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef struct {
        logic       rst;
        logic       en;
        logic       start;
        logic [2:0] mode;
        logic [3:0] amt;
        logic [7:0] d;
        logic       sin;
        logic [7:0] eq;
        logic       es;
        logic       eb;
        logic       ed;
    } vec_t;

    typedef struct packed {
        logic [7:0] q;
        logic       sout;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    exp_t exp_q[$];
    vec_t tbl[17];

    shift_reg_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_reg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W), .RESET_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic en, input logic st,
                                input logic [2:0] m, input logic [3:0] a,
                                input logic [7:0] dd, input logic si,
                                input logic [7:0] eq, input logic es,
                                input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.en = en; v.start = st; v.mode = m; v.amt = a;
        v.d = dd; v.sin = si; v.eq = eq; v.es = es; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, check after the edge.
    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        exp_t got;
        rst        = v.rst;
        bus.enable = v.en;
        bus.start  = v.start;
        bus.mode   = v.mode;
        bus.amt    = v.amt;
        bus.d      = v.d;
        bus.sin    = v.sin;
        e.q = v.eq; e.sout = v.es; e.busy = v.eb; e.done = v.ed;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        got.q = bus.q; got.sout = bus.sout; got.busy = bus.busy; got.done = bus.done;
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got q=%02h sout=%b busy=%b done=%b, want q=%02h sout=%b busy=%b done=%b",
                     nm, got.q, got.sout, got.busy, got.done, e.q, e.sout, e.busy, e.done);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;

        //            rst en st mode     amt    d      sin  q      sout busy done
        tbl[0]  = mk(1, 1, 1, M_LOAD,  4'd0, 8'hFF, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, M_LOAD,  4'd0, 8'hFF, 0, 8'h00, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, M_LOAD,  4'd0, 8'hA5, 0, 8'hA5, 0, 0, 1);
        tbl[3]  = mk(0, 1, 0, M_HOLD,  4'd0, 8'h00, 0, 8'hA5, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, M_ROL,   4'd3, 8'h00, 0, 8'h4B, 1, 1, 0);
        tbl[5]  = mk(0, 1, 0, M_HOLD,  4'd0, 8'h00, 0, 8'h96, 0, 1, 0);
        tbl[6]  = mk(0, 1, 0, M_HOLD,  4'd0, 8'h00, 0, 8'h2D, 1, 0, 1);
        tbl[7]  = mk(0, 1, 0, M_HOLD,  4'd0, 8'h00, 0, 8'h2D, 1, 0, 0);
        tbl[8]  = mk(0, 1, 1, M_LOAD,  4'd0, 8'h80, 0, 8'h80, 1, 0, 1);
        tbl[9]  = mk(0, 1, 1, M_SAR,   4'd2, 8'h00, 0, 8'hC0, 0, 1, 0);
        tbl[10] = mk(0, 1, 0, M_HOLD,  4'd0, 8'h00, 0, 8'hE0, 0, 0, 1);
        tbl[11] = mk(0, 1, 1, M_SHR,   4'd1, 8'h00, 1, 8'hF0, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, M_HOLD,  4'd0, 8'h00, 0, 8'hF0, 0, 0, 0);
        tbl[13] = mk(0, 1, 1, M_HOLD,  4'd5, 8'h12, 0, 8'hF0, 0, 0, 1);
        tbl[14] = mk(0, 1, 1, M_SHL,   4'd0, 8'h12, 1, 8'hF0, 0, 0, 1);
        tbl[15] = mk(0, 1, 1, M_CLEAR, 4'd3, 8'h12, 0, 8'h00, 0, 0, 1);
        tbl[16] = mk(0, 0, 1, M_LOAD,  4'd0, 8'h33, 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // SHL by 9 from zero with sin=1; an extra start mid-run must be ignored.
        apply(mk(0, 1, 1, M_SHL, 4'd9, 8'h00, 1, 8'h01, 0, 1, 0), "shl9_e1");
        for (int i = 2; i <= 9; i++) begin
            logic [7:0] eq;
            eq = (i >= 8) ? 8'hFF : 8'((1 << i) - 1);
            apply(mk(0, 1, (i == 4), M_LOAD, 4'd1, 8'h00, 1, eq, (i == 9), (i < 9), (i == 9)),
                  $sformatf("shl9_e%0d", i));
        end
        apply(mk(0, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'hFF, 1, 0, 0), "shl9_after");

        // ROR by 4 on 0x01 with a two-cycle enable stall after the 2nd shift.
        apply(mk(0, 1, 1, M_LOAD, 4'd0, 8'h01, 0, 8'h01, 1, 0, 1), "stall_load");
        apply(mk(0, 1, 1, M_ROR,  4'd4, 8'h00, 0, 8'h80, 1, 1, 0), "stall_e1");
        apply(mk(0, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'h40, 0, 1, 0), "stall_e2");
        apply(mk(0, 0, 1, M_LOAD, 4'd0, 8'hAA, 1, 8'h40, 0, 1, 0), "stall_off1");
        apply(mk(0, 0, 0, M_HOLD, 4'd0, 8'h00, 1, 8'h40, 0, 1, 0), "stall_off2");
        apply(mk(0, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'h20, 0, 1, 0), "stall_e3");
        apply(mk(0, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'h10, 0, 0, 1), "stall_e4");
        apply(mk(0, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'h10, 0, 0, 0), "stall_after");

        // Same rotate, aborted by reset after the 2nd shift: no done pulse.
        apply(mk(0, 1, 1, M_LOAD, 4'd0, 8'h01, 0, 8'h01, 0, 0, 1), "abort_load");
        apply(mk(0, 1, 1, M_ROR,  4'd4, 8'h00, 0, 8'h80, 1, 1, 0), "abort_e1");
        apply(mk(0, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'h40, 0, 1, 0), "abort_e2");
        apply(mk(1, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0), "abort_rst");
        apply(mk(0, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0), "abort_after1");
        apply(mk(0, 1, 0, M_HOLD, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0), "abort_after2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
